// File: rtl/store_queue_pkg.sv
// Shared types, constants and helpers for the store queue: entry layout, funct3 size codes, byte-lane mask.
// Entry field widths are fixed by this package; the store_queue parameters default to the same values.
package store_queue_pkg;

    localparam int SQ_DEPTH  = 8;
    localparam int SQ_ADDR_W = 32;
    localparam int SQ_DATA_W = 32;
    localparam int SQ_ROB_W  = 5;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [SQ_ADDR_W-1:0] addr;
        logic [SQ_DATA_W-1:0] data;
        logic [3:0]           wstrb;
        logic [SQ_ROB_W-1:0]  rob_id;
        logic                 addr_valid;
        logic                 committed;
        logic                 valid;
    } SQ_ENTRY_t;

    // Only funct3[1:0] encodes access size; the sign bit of loads is irrelevant here.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] base;
        case (funct3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << addr_lo;
    endfunction

endpackage

// File: rtl/store_queue_fwd.sv
// Combinational store-to-load forwarding search over entries [head, ld_sq_tail), youngest match wins.
// Zero latency; stalls the load on any unexecuted older store or on a partially covering youngest match.
module sq_forward_unit
    import store_queue_pkg::*;
#(
    parameter int DEPTH      = SQ_DEPTH,
    parameter int ADDR_WIDTH = SQ_ADDR_W,
    parameter int DATA_WIDTH = SQ_DATA_W,
    parameter int SQ_PTR_W   = $clog2(DEPTH) + 1
) (
    input  SQ_ENTRY_t               i_ent [DEPTH],
    input  logic [SQ_PTR_W-1:0]     i_head,
    input  logic                    i_ld_valid,
    input  logic [ADDR_WIDTH-1:0]   i_ld_addr,
    input  logic [2:0]              i_ld_funct3,
    input  logic [SQ_PTR_W-1:0]     i_ld_sq_tail,
    output logic                    o_hit,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_stall
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [3:0]            w_ld_mask;
    logic [SQ_PTR_W-1:0]   w_older;
    logic [IDX_W-1:0]      w_idx [DEPTH];
    logic                  w_unexec;
    logic                  w_found;
    logic                  w_cover;
    logic [DATA_WIDTH-1:0] w_fdata;

    always_comb begin
        w_ld_mask = byte_mask(i_ld_funct3, i_ld_addr[1:0]);
        w_older   = i_ld_sq_tail - i_head;
        w_unexec  = 1'b0;
        w_found   = 1'b0;
        w_cover   = 1'b0;
        w_fdata   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx[k] = i_head[IDX_W-1:0] + k[IDX_W-1:0];
        end
        // Walk oldest to youngest so the last hit recorded is the youngest older store.
        for (int k = 0; k < DEPTH; k++) begin
            if (({1'b0, k[IDX_W-1:0]} < w_older) && i_ent[w_idx[k]].valid) begin
                if (!i_ent[w_idx[k]].addr_valid) begin
                    w_unexec = 1'b1;
                end else if ((i_ent[w_idx[k]].addr[ADDR_WIDTH-1:2] == i_ld_addr[ADDR_WIDTH-1:2]) &&
                             ((i_ent[w_idx[k]].wstrb & w_ld_mask) != 4'b0000)) begin
                    w_found = 1'b1;
                    w_cover = ((i_ent[w_idx[k]].wstrb & w_ld_mask) == w_ld_mask);
                    w_fdata = i_ent[w_idx[k]].data;
                end
            end
        end
    end

    always_comb begin
        o_hit   = 1'b0;
        o_stall = 1'b0;
        o_data  = '0;
        if (i_ld_valid) begin
            if (w_unexec) begin
                o_stall = 1'b1;
            end else if (w_found) begin
                if (w_cover) begin
                    o_hit  = 1'b1;
                    o_data = w_fdata;
                end else begin
                    o_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: in-order alloc, out-of-order AGU fill, ROB commit, in-order drain to D-memory.
// Drain request is combinational from the head entry and holds while mem_req_ready is low; alloc blocks when full or flushing.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int   DEPTH      = SQ_DEPTH,
    parameter int   ADDR_WIDTH = SQ_ADDR_W,
    parameter int   DATA_WIDTH = SQ_DATA_W,
    parameter int   ROB_WIDTH  = SQ_ROB_W,
    localparam int  SQ_PTR_W   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [ROB_WIDTH-1:0]  alloc_rob_id,
    output logic [SQ_PTR_W-1:0]   alloc_store_id,
    input  logic                  exe_valid,
    input  logic [SQ_PTR_W-1:0]   exe_store_id,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic [DATA_WIDTH-1:0] exe_data,
    input  logic [2:0]            exe_funct3,
    input  logic                  commit_valid,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    input  logic [SQ_PTR_W-1:0]   ld_sq_tail,
    output logic                  ld_fwd_hit,
    output logic [DATA_WIDTH-1:0] ld_fwd_data,
    output logic                  ld_stall,
    output logic                  full,
    output logic                  empty,
    output logic [SQ_PTR_W-1:0]   count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [SQ_PTR_W-1:0] r_head;
    logic [SQ_PTR_W-1:0] r_cmt;
    logic [SQ_PTR_W-1:0] r_tail;
    SQ_ENTRY_t           r_ent [DEPTH];

    logic [IDX_W-1:0]    w_head_idx;
    logic [IDX_W-1:0]    w_cmt_idx;
    logic [IDX_W-1:0]    w_tail_idx;
    logic [IDX_W-1:0]    w_exe_idx;
    logic                w_alloc_fire;
    logic                w_exe_ok;
    logic                w_cmt_fire;
    logic                w_drain_fire;
    logic [SQ_PTR_W-1:0] w_exe_off;
    logic [SQ_PTR_W-1:0] w_live;
    logic [SQ_PTR_W-1:0] w_cmt_next;
    logic [SQ_PTR_W-1:0] w_kill_span;
    logic [DEPTH-1:0]    w_kill;
    logic [3:0]          w_exe_wstrb;
    logic [DATA_WIDTH-1:0] w_exe_shdata;
    SQ_ENTRY_t           w_new_ent;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_cmt_idx  = r_cmt[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_exe_idx  = exe_store_id[IDX_W-1:0];

    assign full           = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign empty          = (r_head == r_tail);
    assign count          = r_tail - r_head;
    assign alloc_ready    = !full && !flush;
    assign alloc_store_id = r_tail;

    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign w_exe_off    = exe_store_id - r_cmt;
    assign w_live       = r_tail - r_cmt;
    assign w_exe_ok     = exe_valid && !flush && (w_exe_off < w_live);
    assign w_cmt_fire   = commit_valid && (r_cmt != r_tail);
    assign w_cmt_next   = r_cmt + {{(SQ_PTR_W-1){1'b0}}, w_cmt_fire};
    assign w_kill_span  = r_tail - w_cmt_next;

    assign w_exe_wstrb  = byte_mask(exe_funct3, exe_addr[1:0]);
    assign w_exe_shdata = exe_data << {exe_addr[1:0], 3'b000};

    assign mem_req_valid = (r_head != r_cmt);
    assign w_drain_fire  = mem_req_valid && mem_req_ready;
    assign mem_req_addr  = mem_req_valid ? {r_ent[w_head_idx].addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_req_data  = mem_req_valid ? r_ent[w_head_idx].data  : '0;
    assign mem_req_wstrb = mem_req_valid ? r_ent[w_head_idx].wstrb : 4'b0000;

    // Flush kills every entry at or beyond the post-commit cmt pointer; committed ones sit below it.
    always_comb begin
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = flush && ({1'b0, (i[IDX_W-1:0] - w_cmt_next[IDX_W-1:0])} < w_kill_span);
        end
    end

    always_comb begin
        w_new_ent        = '0;
        w_new_ent.valid  = 1'b1;
        w_new_ent.rob_id = alloc_rob_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    r_ent[i].valid      <= 1'b0;
                    r_ent[i].addr_valid <= 1'b0;
                end
            end
            if (w_drain_fire) begin
                r_ent[w_head_idx] <= '0;
            end
            if (w_cmt_fire) begin
                r_ent[w_cmt_idx].committed <= 1'b1;
            end
            if (w_exe_ok) begin
                r_ent[w_exe_idx].addr       <= exe_addr;
                r_ent[w_exe_idx].data       <= w_exe_shdata;
                r_ent[w_exe_idx].wstrb      <= w_exe_wstrb;
                r_ent[w_exe_idx].addr_valid <= 1'b1;
            end
            if (w_alloc_fire) begin
                r_ent[w_tail_idx] <= w_new_ent;
            end
            r_head <= r_head + {{(SQ_PTR_W-1){1'b0}}, w_drain_fire};
            r_cmt  <= w_cmt_next;
            r_tail <= flush ? w_cmt_next : (r_tail + {{(SQ_PTR_W-1){1'b0}}, w_alloc_fire});
        end
    end

    sq_forward_unit #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SQ_PTR_W   (SQ_PTR_W)
    ) u_fwd (
        .i_ent        (r_ent),
        .i_head       (r_head),
        .i_ld_valid   (ld_valid),
        .i_ld_addr    (ld_addr),
        .i_ld_funct3  (ld_funct3),
        .i_ld_sq_tail (ld_sq_tail),
        .o_hit        (ld_fwd_hit),
        .o_data       (ld_fwd_data),
        .o_stall      (ld_stall)
    );

    // Illegal-use checks: misaligned halfword/word stores and commits of empty or unexecuted entries.
    always @(posedge clk) begin
        if (rst_n) begin
            if (exe_valid && (exe_funct3 == F3_SH)) assert (exe_addr[0] == 1'b0);
            if (exe_valid && (exe_funct3 == F3_SW)) assert (exe_addr[1:0] == 2'b00);
            if (commit_valid) assert (r_cmt != r_tail);
            if (w_cmt_fire) assert (r_ent[w_cmt_idx].addr_valid);
        end
    end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised, byte-granular circular store queue.
- Successor to the single-entry store buffer. Adds in-order allocation at dispatch, out-of-order address/data fill from the store AGU, and ROB-driven commit.
- Drains committed stores to the data memory port with a valid/ready handshake.
- Provides age-correct store-to-load forwarding. Sits between dispatch, the LSU execute stage, the ROB commit port and the D-memory write port.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, store data width; fixed 32 this generation (4 byte lanes).
- ROB_WIDTH, 5, ROB id width.
- SQ_PTR_W, $clog2(DEPTH)+1, derived localparam: pointer/store_id width including wrap bit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch requests one store entry
- alloc_ready  out  1  entry available this cycle
- alloc_rob_id  in  ROB_WIDTH  ROB id of allocating store
- alloc_store_id  out  SQ_PTR_W  id given to allocating store (current tail)
- exe_valid  in  1  AGU result valid
- exe_store_id  in  SQ_PTR_W  target entry
- exe_addr  in  ADDR_WIDTH  store byte address
- exe_data  in  DATA_WIDTH  rs2 value, unshifted
- exe_funct3  in  3  000 SB / 001 SH / 010 SW
- commit_valid  in  1  ROB commits the oldest uncommitted store
- flush  in  1  mispredict: discard all uncommitted entries
- mem_req_valid  out  1  head store ready to write
- mem_req_ready  in  1  memory accepts
- mem_req_addr  out  ADDR_WIDTH  word-aligned address
- mem_req_data  out  DATA_WIDTH  lane-shifted data
- mem_req_wstrb  out  4  byte enables
- ld_valid  in  1  load forwarding lookup
- ld_addr  in  ADDR_WIDTH  load byte address
- ld_funct3  in  3  load size (low 2 bits used)
- ld_sq_tail  in  SQ_PTR_W  tail snapshot taken at load dispatch
- ld_fwd_hit  out  1  load fully covered by one older store
- ld_fwd_data  out  DATA_WIDTH  forwarded word, lane-aligned
- ld_stall  out  1  load must wait
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  SQ_PTR_W  occupied entries

Behaviour:
- Pointers: head (drain), cmt (oldest uncommitted), tail (next allocation), each SQ_PTR_W bits.
  - Index = low $clog2(DEPTH) bits; the MSB is the wrap bit.
  - Invariant: head ≤ cmt ≤ tail in modular order.
  - count = tail − head; full/empty compare index plus wrap bit.
- Reset (async, rst_n=0):
  - All pointers 0; all entry valid/addr_valid/committed flags 0.
  - Outputs: alloc_ready=1, mem_req_valid=0, mem_req_addr/data/wstrb=0, ld_fwd_hit=0, ld_fwd_data=0, ld_stall=0, full=0, empty=1, count=0.
  - Reset mid-drain drops the pending request; no handshake completes.
- Allocate:
  - alloc_ready = !full && !flush.
  - On alloc_valid&&alloc_ready: entry[tail] gets valid=1, addr_valid=0, committed=0 and rob_id; tail++.
  - alloc_store_id = tail, combinational.
  - No same-cycle bypass: when full, a drain does not enable allocation until the next cycle.
- Execute:
  - On exe_valid, entry[exe_store_id] gets wstrb = base mask (SB 0001, SH 0011, SW 1111) << addr[1:0], data = exe_data << 8*addr[1:0], addr, and addr_valid=1.
  - Ignored if the id is not in [cmt, tail) or flush is high the same cycle.
  - Misaligned SH/SW is illegal (assertion).
- Commit:
  - On commit_valid, cmt++.
  - Entry must be addr_valid (assertion); commit with cmt==tail is illegal.
- Flush: tail <= cmt.
  - A same-cycle commit is applied first, so tail <= cmt+1.
  - A same-cycle alloc is dropped.
  - Committed entries are never flushed.
- Drain:
  - mem_req_valid = (head != cmt); request fields come from entry[head], combinational from registers.
  - On valid&&ready: entry invalidated, head++.
  - Fields stay stable while valid && !ready.
- Forwarding: combinational, same cycle. Older stores are entries in [head, ld_sq_tail).
  - Load mask uses the same size encoding as stores: base mask << ld_addr[1:0].
  - Any older entry with addr_valid=0 → ld_stall=1, hit=0.
  - Otherwise, scan youngest to oldest for the first entry with equal word address (addr[ADDR_WIDTH-1:2]) and (wstrb & ld_mask) != 0:
    - that entry's wstrb ⊇ ld_mask → hit=1, data = its shifted data;
    - partial cover → ld_stall=1.
  - No match → hit=0, stall=0; the load reads memory.
  - ld_valid=0 forces hit=0, stall=0.
- Simultaneous alloc, exe, commit, drain and lookup in one cycle are all legal. The lookup sees pre-update state.

Decomposition:
- typedef_pkg gains SQ_ENTRY_t: addr, data, wstrb[3:0], rob_id, addr_valid, committed, valid.
- parameter_pkg gains SQ_DEPTH and funct3 constants F3_SB/F3_SH/F3_SW.
- typedef_pkg also gets a function byte_mask(funct3, addr_lo).
- One sub-module: sq_forward_unit, a combinational age-ordered search over the entry array given head and ld_sq_tail.

Test Plan:
- Reset, alloc 8 with DEPTH=8 → ids 0..7, full=1 and alloc_ready=0 after the 8th; count=8.
- SB addr 0x103 data 0xAB; commit; ready=1 → mem_req addr 0x100, wstrb 1000, data 0xAB000000; empty next cycle.
- SW 0x200=0xDEADBEEF executed, LW 0x200 with snapshot after it → hit=1, data 0xDEADBEEF. LW with snapshot before it → no hit, no stall.
- Older store unexecuted → ld_stall=1. SB 0x201 then LW 0x200 → partial cover, stall=1. Two SWs to 0x200 (0x1, then 0x2) → forward 0x2.
- Alloc 4, commit 2, flush with a simultaneous commit → tail=cmt=3, count=3; drain exactly 3 requests.
- Pointer wrap: 20 alloc/commit/drain cycles with mem_req_ready toggling 1/0 → every store is drained once, in order, fields stable while stalled; full/empty are correct across the wrap.
